// File: rtl/dunc_timing_ctrl_pkg.sv
// Shared definitions for the dunc timing-and-control sequencer: opcodes,
// sequencer state encoding and default sizing.
package dunc_pkg;

  localparam int DUNC_NT_DEFAULT  = 4;
  localparam int DUNC_OPW_DEFAULT = 4;
  localparam int DUNC_CW_DEFAULT  = 16;

  localparam logic [3:0] OPC_NOP = 4'h0;
  localparam logic [3:0] OPC_LDA = 4'h1;
  localparam logic [3:0] OPC_STA = 4'h2;
  localparam logic [3:0] OPC_ADD = 4'h3;
  localparam logic [3:0] OPC_SUB = 4'h4;
  localparam logic [3:0] OPC_JMP = 4'h5;
  localparam logic [3:0] OPC_JZ  = 4'h6;
  localparam logic [3:0] OPC_HLT = 4'hF;

  typedef enum logic [1:0] {
    RUN_FETCH = 2'd0,
    RUN_EXEC  = 2'd1,
    HALT      = 2'd2
  } dunc_state_e;

  // True when at most one bit of an 8-bit (or narrower, zero-extended) vector is set.
  function automatic logic dunc_onehot0(input logic [7:0] v);
    int n;
    n = 0;
    for (int i = 0; i < 8; i++) n += int'(v[i]);
    return (n <= 1);
  endfunction

endpackage

// File: rtl/dunc_timing_ctrl_tring.sv
// NT-bit one-hot T-state ring: rotates each clock unless held, clears to all-zero,
// and restarts at T[0] on the first unheld clock after being cleared.
module dunc_tring
  import dunc_pkg::*;
#(
  parameter int NT = DUNC_NT_DEFAULT
) (
  input  logic          CLK,
  input  logic          RESET,
  input  logic          HOLD,
  input  logic          CLEAR,
  output logic [NT-1:0] T
);

  logic [NT-1:0] t_reg;
  logic [NT-1:0] t_next;

  // An all-zero ring re-enters at T[0] through the feedback into bit 0.
  assign t_next[0] = t_reg[NT-1] | (t_reg == '0);

  genvar gi;
  generate
    for (gi = 1; gi < NT; gi++) begin : g_rot
      assign t_next[gi] = t_reg[gi-1];
    end
  endgenerate

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      t_reg <= NT'(1);
    end else if (CLEAR) begin
      t_reg <= '0;
    end else if (!HOLD) begin
      t_reg <= t_next;
    end
  end

  assign T = t_reg;

  a_ring_onehot0: assert property (@(posedge CLK) disable iff (!RESET)
    dunc_onehot0(8'(t_reg)));

endmodule

// File: rtl/dunc_timing_ctrl.sv
// dunc timing-and-control sequencer: T ring, FETCH/EXECUTE phase, STA write chain,
// wait states, halt/resume and retire counter. Optional single-step: DUNC_SINGLE_STEP_EN.
module dunc_timing_ctrl
  import dunc_pkg::*;
#(
  parameter int              NT     = DUNC_NT_DEFAULT,
  parameter int              OPW    = DUNC_OPW_DEFAULT,
  parameter logic [OPW-1:0]  OP_STA = OPW'(OPC_STA),
  parameter int              CW     = DUNC_CW_DEFAULT
) (
  input  logic           CLK,
  input  logic           RESET,
`ifdef DUNC_SINGLE_STEP_EN
  input  logic           STEP,
`endif
  input  logic [OPW-1:0] OPCODE,
  input  logic           MEM_READY,
  input  logic           HALT_REQ,
  output logic [NT-1:0]  T,
  output logic           FETCH,
  output logic           EXECUTE,
  output logic           IR_LOAD,
  output logic           PC_INC,
  output logic           I_STA,
  output logic           SETWRITE,
  output logic           CLRWRITE,
  output logic           WRITE,
  output logic           DO_WRITE,
  output logic           HALTED,
  output logic [CW-1:0]  INSTR_CNT
);

  dunc_state_e   state_reg;
  logic [NT-1:0] t_vec;
  logic          t_last;
  logic          wrap;
  logic          exec_wrap;
  logic          go_halt;
  logic          leave_halt;
  logic          ring_hold;
  logic          ring_clear;
  logic          write_reg;
  logic [CW-1:0] cnt_reg;

  assign FETCH   = (state_reg == RUN_FETCH);
  assign EXECUTE = (state_reg == RUN_EXEC);
  assign HALTED  = (state_reg == HALT);

  // The ring is all-zero while halted, so t_last (and every strobe) is quiet there.
  assign t_last    = t_vec[NT-1];
  assign wrap      = t_last & MEM_READY;
  assign exec_wrap = EXECUTE & wrap;

`ifdef DUNC_SINGLE_STEP_EN
  // A stepped instruction re-enters HALT at its execute wrap regardless of HALT_REQ;
  // while the feature is present HALT is left only through a STEP rising edge.
  logic step_prev_reg;
  logic step_mode_reg;
  logic step_rise;

  assign step_rise  = STEP & ~step_prev_reg;
  assign leave_halt = HALTED & step_rise;
  assign go_halt    = exec_wrap & (HALT_REQ | step_mode_reg);

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      step_prev_reg <= 1'b0;
      step_mode_reg <= 1'b0;
    end else begin
      step_prev_reg <= STEP;
      if (leave_halt) begin
        step_mode_reg <= 1'b1;
      end else if (exec_wrap) begin
        step_mode_reg <= 1'b0;
      end
    end
  end
`else
  assign leave_halt = HALTED & ~HALT_REQ;
  assign go_halt    = exec_wrap & HALT_REQ;
`endif

  assign ring_hold  = t_last & ~MEM_READY;
  assign ring_clear = go_halt | (HALTED & ~leave_halt);

  dunc_tring #(
    .NT (NT)
  ) u_tring (
    .CLK   (CLK),
    .RESET (RESET),
    .HOLD  (ring_hold),
    .CLEAR (ring_clear),
    .T     (t_vec)
  );

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state_reg <= RUN_FETCH;
    end else begin
      case (state_reg)
        RUN_FETCH: if (wrap) state_reg <= RUN_EXEC;
        RUN_EXEC:  if (wrap) state_reg <= go_halt ? HALT : RUN_FETCH;
        HALT:      if (leave_halt) state_reg <= RUN_FETCH;
        default:   state_reg <= RUN_FETCH;
      endcase
    end
  end

  assign T        = t_vec;
  assign IR_LOAD  = FETCH & wrap;
  assign PC_INC   = FETCH & wrap;
  assign I_STA    = EXECUTE & (OPCODE == OP_STA);
  assign SETWRITE = I_STA & t_vec[0];
  assign DO_WRITE = write_reg & t_last;
  assign CLRWRITE = write_reg & wrap;

  // Set has priority over clear on the write-pending flag.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      write_reg <= 1'b0;
    end else if (SETWRITE) begin
      write_reg <= 1'b1;
    end else if (CLRWRITE) begin
      write_reg <= 1'b0;
    end
  end

  assign WRITE = write_reg;

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      cnt_reg <= '0;
    end else if (exec_wrap) begin
      cnt_reg <= cnt_reg + CW'(1);
    end
  end

  assign INSTR_CNT = cnt_reg;

  a_set_clr_exclusive: assert property (@(posedge CLK) disable iff (!RESET)
    !(SETWRITE && CLRWRITE));

endmodule

// File: tb/tb_dunc_timing_ctrl.sv
// Self-checking bench for dunc_timing_ctrl: NT=4 and NT=5 instances in lockstep,
// directed steps plus random MEM_READY/HALT_REQ/OPCODE against a phase/index model.
module tb_dunc_timing_ctrl;

  logic       CLK = 1'b0;
  logic       RESET = 1'b0;
  logic       STEP = 1'b0;
  logic [3:0] OPCODE = 4'h0;
  logic       MEM_READY = 1'b0;
  logic       HALT_REQ = 1'b0;

  always #5 CLK = ~CLK;

  logic [3:0]  t4;
  logic [4:0]  t5;
  logic        fetch4, exec4, irl4, pci4, ista4, setw4, clrw4, wr4, dow4, halt4;
  logic        fetch5, exec5, irl5, pci5, ista5, setw5, clrw5, wr5, dow5, halt5;
  logic [15:0] cnt4, cnt5;

  dunc_timing_ctrl #(.NT(4), .OPW(4), .OP_STA(4'h2), .CW(16)) dut4 (
    .CLK(CLK), .RESET(RESET),
`ifdef DUNC_SINGLE_STEP_EN
    .STEP(STEP),
`endif
    .OPCODE(OPCODE), .MEM_READY(MEM_READY), .HALT_REQ(HALT_REQ),
    .T(t4), .FETCH(fetch4), .EXECUTE(exec4), .IR_LOAD(irl4), .PC_INC(pci4),
    .I_STA(ista4), .SETWRITE(setw4), .CLRWRITE(clrw4), .WRITE(wr4),
    .DO_WRITE(dow4), .HALTED(halt4), .INSTR_CNT(cnt4)
  );

  dunc_timing_ctrl #(.NT(5), .OPW(4), .OP_STA(4'h2), .CW(16)) dut5 (
    .CLK(CLK), .RESET(RESET),
`ifdef DUNC_SINGLE_STEP_EN
    .STEP(STEP),
`endif
    .OPCODE(OPCODE), .MEM_READY(MEM_READY), .HALT_REQ(HALT_REQ),
    .T(t5), .FETCH(fetch5), .EXECUTE(exec5), .IR_LOAD(irl5), .PC_INC(pci5),
    .I_STA(ista5), .SETWRITE(setw5), .CLRWRITE(clrw5), .WRITE(wr5),
    .DO_WRITE(dow5), .HALTED(halt5), .INSTR_CNT(cnt5)
  );

  // Reference model: phase (0 fetch, 1 execute, 2 halted), T index, write flag, count.
  int nt_of [2] = '{4, 5};
  int m_ph  [2];
  int m_ti  [2];
  bit m_wr  [2];
  int m_cnt [2];

  int total = 0;
  int passed = 0;
  int failed = 0;
  int cyc = 0;
  int irl5_pulses = 0;
  bit saw_wr = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      m_ph[k] = 0; m_ti[k] = 0; m_wr[k] = 1'b0; m_cnt[k] = 0;
    end
  endtask

  task automatic check_inst(input int k);
    bit h, last;
    logic [31:0] e_t;
    bit e_f, e_e, e_irl, e_ista, e_setw, e_do, e_clr;
    logic [31:0] o_t;
    logic o_f, o_e, o_irl, o_pci, o_ista, o_setw, o_clr, o_wr, o_do, o_h;
    logic [15:0] o_cnt;
    string p;
    h      = (m_ph[k] == 2);
    last   = !h && (m_ti[k] == nt_of[k] - 1);
    e_t    = h ? 32'd0 : (32'd1 << m_ti[k]);
    e_f    = (m_ph[k] == 0);
    e_e    = (m_ph[k] == 1);
    e_irl  = e_f && last && MEM_READY;
    e_ista = e_e && (OPCODE == 4'h2);
    e_setw = e_ista && (m_ti[k] == 0);
    e_do   = m_wr[k] && last;
    e_clr  = e_do && MEM_READY;
    if (k == 0) begin
      p = "nt4"; o_t = 32'(t4); o_f = fetch4; o_e = exec4; o_irl = irl4; o_pci = pci4;
      o_ista = ista4; o_setw = setw4; o_clr = clrw4; o_wr = wr4; o_do = dow4;
      o_h = halt4; o_cnt = cnt4;
    end else begin
      p = "nt5"; o_t = 32'(t5); o_f = fetch5; o_e = exec5; o_irl = irl5; o_pci = pci5;
      o_ista = ista5; o_setw = setw5; o_clr = clrw5; o_wr = wr5; o_do = dow5;
      o_h = halt5; o_cnt = cnt5;
    end
    chk({p, ".T"}, o_t, e_t);
    chk({p, ".FETCH"}, 32'(o_f), 32'(e_f));
    chk({p, ".EXECUTE"}, 32'(o_e), 32'(e_e));
    chk({p, ".IR_LOAD"}, 32'(o_irl), 32'(e_irl));
    chk({p, ".PC_INC"}, 32'(o_pci), 32'(e_irl));
    chk({p, ".I_STA"}, 32'(o_ista), 32'(e_ista));
    chk({p, ".SETWRITE"}, 32'(o_setw), 32'(e_setw));
    chk({p, ".CLRWRITE"}, 32'(o_clr), 32'(e_clr));
    chk({p, ".WRITE"}, 32'(o_wr), 32'(m_wr[k]));
    chk({p, ".DO_WRITE"}, 32'(o_do), 32'(e_do));
    chk({p, ".HALTED"}, 32'(o_h), 32'(h));
    chk({p, ".INSTR_CNT"}, 32'(o_cnt), 32'(m_cnt[k] % 65536));
  endtask

  task automatic model_step(input int k);
    bit last, setw, clr;
    if (m_ph[k] == 2) begin
      if (!HALT_REQ) begin m_ph[k] = 0; m_ti[k] = 0; end
    end else begin
      last = (m_ti[k] == nt_of[k] - 1);
      setw = (m_ph[k] == 1) && (OPCODE == 4'h2) && (m_ti[k] == 0);
      clr  = m_wr[k] && last && MEM_READY;
      if (setw) m_wr[k] = 1'b1;
      else if (clr) m_wr[k] = 1'b0;
      if (!last) m_ti[k]++;
      else if (MEM_READY) begin
        m_ti[k] = 0;
        if (m_ph[k] == 0) m_ph[k] = 1;
        else begin
          m_cnt[k] = (m_cnt[k] + 1) % 65536;
          m_ph[k] = HALT_REQ ? 2 : 0;
        end
      end
    end
  endtask

  // One clock: drive at negedge, check before the edge, advance the model after it.
  task automatic cycle(input logic rst, input logic mr, input logic [3:0] op, input logic hr);
    @(negedge CLK);
    RESET = rst; MEM_READY = mr; OPCODE = op; HALT_REQ = hr;
    #1;
    check_inst(0);
    check_inst(1);
    irl5_pulses += int'(irl5);
    saw_wr |= (wr4 | wr5);
    $display("cyc %0d rst=%b mr=%b op=%h hr=%b | t4=%b cnt4=%0d | t5=%b cnt5=%0d",
             cyc, rst, mr, op, hr, t4, cnt4, t5, cnt5);
    @(posedge CLK);
    cyc++;
    if (RESET) begin
      model_step(0);
      model_step(1);
    end
  endtask

  initial begin
    int base;
    logic [3:0] rop;
    logic rhr;

    // Reset held, then released into a free run with a non-STA opcode.
    model_reset();
    for (int i = 0; i < 3; i++) cycle(1'b0, 1'b0, 4'h0, 1'b0);
    saw_wr = 1'b0;
    for (int i = 0; i < 40; i++) cycle(1'b1, 1'b1, 4'h1, 1'b0);
    #1;
    chk("free_run_cnt_nt4", 32'(cnt4), 32'd5);
    chk("free_run_cnt_nt5", 32'(cnt5), 32'd4);
    chk("free_run_no_write", 32'(saw_wr), 32'd0);

    // STA instructions back to back.
    saw_wr = 1'b0;
    for (int i = 0; i < 24; i++) cycle(1'b1, 1'b1, 4'h2, 1'b0);
    chk("sta_write_seen", 32'(saw_wr), 32'd1);

    // Wait states on NT=5 fetch T[4].
    for (int i = 0; i < 30 && !(m_ph[1] == 0 && m_ti[1] == 4); i++) cycle(1'b1, 1'b1, 4'h1, 1'b0);
    chk("reach_fetch_t4_nt5", 32'(m_ph[1] == 0 && m_ti[1] == 4), 32'd1);
    irl5_pulses = 0;
    for (int i = 0; i < 3; i++) cycle(1'b1, 1'b0, 4'h1, 1'b0);
    #1;
    chk("wait_t_hold_nt5", 32'(t5), 32'd16);
    cycle(1'b1, 1'b1, 4'h1, 1'b0);
    #1;
    chk("wait_irl_once_nt5", 32'(irl5_pulses), 32'd1);
    chk("wait_exec_t0_nt5", 32'({exec5, t5}), 32'h21);

    // Halt requested at fetch T[1] of NT=4: instruction completes then halts.
    for (int i = 0; i < 30 && !(m_ph[0] == 0 && m_ti[0] == 1); i++) cycle(1'b1, 1'b1, 4'h1, 1'b0);
    chk("reach_fetch_t1_nt4", 32'(m_ph[0] == 0 && m_ti[0] == 1), 32'd1);
    base = int'(cnt4);
    for (int i = 0; i < 20 && m_ph[0] != 2; i++) cycle(1'b1, 1'b1, 4'h1, 1'b1);
    #1;
    chk("halt_halted_nt4", 32'(halt4), 32'd1);
    chk("halt_t_zero_nt4", 32'(t4), 32'd0);
    chk("halt_cnt_once_nt4", 32'(cnt4), 32'((base + 1) % 65536));
    for (int i = 0; i < 4; i++) cycle(1'b1, 1'b1, 4'h1, 1'b1);
    #1;
    chk("halt_cnt_frozen_nt4", 32'(cnt4), 32'((base + 1) % 65536));
    cycle(1'b1, 1'b1, 4'h1, 1'b0);
    #1;
    chk("resume_fetch_t0_nt4", 32'({fetch4, t4}), 32'h11);

    // Random run; opcode changes only while neither instance is executing.
    rop = 4'h1;
    rhr = 1'b0;
    for (int i = 0; i < 300; i++) begin
      if (m_ph[0] != 1 && m_ph[1] != 1) rop = ($urandom_range(0, 2) == 0) ? 4'h2 : 4'($urandom_range(0, 15));
      if ($urandom_range(0, 11) == 0) rhr = ~rhr;
      cycle(1'b1, ($urandom_range(0, 3) != 0), rop, rhr);
    end
    for (int i = 0; i < 2; i++) cycle(1'b1, 1'b1, rop, 1'b0);

    // Reset mid-write at STA execute T[2] of NT=4.
    for (int i = 0; i < 60 && !(m_ph[0] == 1 && m_ti[0] == 2); i++) cycle(1'b1, 1'b1, 4'h2, 1'b0);
    chk("reach_exec_t2_nt4", 32'(m_ph[0] == 1 && m_ti[0] == 2), 32'd1);
    #2;
    chk("pre_reset_write_nt4", 32'(wr4), 32'd1);
    RESET = 1'b0;
    #1;
    chk("async_reset_write_nt4", 32'(wr4), 32'd0);
    chk("async_reset_dowrite_nt4", 32'(dow4), 32'd0);
    chk("async_reset_t_nt4", 32'({fetch4, t4}), 32'h11);
    chk("async_reset_cnt_nt4", 32'(cnt4), 32'd0);
    model_reset();
    cycle(1'b0, 1'b1, 4'h2, 1'b0);
    for (int i = 0; i < 3; i++) cycle(1'b1, 1'b1, 4'h2, 1'b0);

    // Reset during a write wait state (T[3] held): DO_WRITE drops without a clock.
    for (int i = 0; i < 60 && !(m_ph[0] == 1 && m_ti[0] == 3); i++) cycle(1'b1, 1'b1, 4'h2, 1'b0);
    chk("reach_exec_t3_nt4", 32'(m_ph[0] == 1 && m_ti[0] == 3), 32'd1);
    @(negedge CLK);
    MEM_READY = 1'b0;
    #1;
    chk("pre_reset_dowrite_nt4", 32'(dow4), 32'd1);
    RESET = 1'b0;
    #1;
    chk("async_reset_dowrite2_nt4", 32'(dow4), 32'd0);
    chk("async_reset_write2_nt4", 32'(wr4), 32'd0);
    model_reset();
    cycle(1'b0, 1'b1, 4'h1, 1'b0);
    for (int i = 0; i < 10; i++) cycle(1'b1, 1'b1, 4'h1, 1'b0);
    #1;
    chk("post_reset_cnt_nt4", 32'(cnt4), 32'd1);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/dunc_timing_ctrl.md
Name: dunc_timing_ctrl

Overview:
- Parametrised timing-and-control sequencer for the dunc accumulator CPU family; successor to the fixed 4-state T0..T3 generator.
- Generates a one-hot T-state ring, the FETCH/EXECUTE phase, and the IR/PC strobes.
- Implements the STA write-control chain: SETWRITE, WRITE, DO_WRITE and CLRWRITE.
- Adds memory wait states, halt/resume and a retired-instruction counter; sits between the instruction register decode and the memory/datapath enables.

Parameters:
- NT, 4, T-states per phase; legal values 3..8.
- OPW, 4, opcode width.
- OP_STA, 4'h2, opcode value that decodes to STA.
- CW, 16, width of the retired-instruction counter.

Ports:
- CLK  in  1  system clock; all state updates on rising edge.
- RESET  in  1  asynchronous, active-low reset.
- OPCODE  in  OPW  opcode field from the instruction register.
- MEM_READY  in  1  memory access completes this cycle.
- HALT_REQ  in  1  level request to halt at the next instruction boundary.
- T  out  NT  one-hot T-state vector.
- FETCH  out  1  fetch phase active.
- EXECUTE  out  1  execute phase active.
- IR_LOAD  out  1  load instruction register (1-cycle pulse).
- PC_INC  out  1  increment PC (1-cycle pulse).
- I_STA  out  1  STA instruction decoded during EXECUTE.
- SETWRITE  out  1  pulse that sets WRITE.
- CLRWRITE  out  1  pulse that clears WRITE.
- WRITE  out  1  registered write-pending flag.
- DO_WRITE  out  1  memory write strobe.
- HALTED  out  1  sequencer is halted.
- INSTR_CNT  out  CW  count of retired instructions.

Behaviour:
- Reset (RESET=0, asynchronous):
  - T=1 (T[0]), FETCH=1, EXECUTE=0, WRITE=0, HALTED=0, INSTR_CNT=0.
  - All pulse outputs are 0.
  - A reset asserted mid-write drops WRITE and DO_WRITE immediately, without waiting for a clock.
- States: RUN_FETCH, RUN_EXEC, HALT.
  - FETCH=1 only in RUN_FETCH; EXECUTE=1 only in RUN_EXEC; T=0 and HALTED=1 in HALT.
- T ring:
  - Advances T[k] to T[k+1] each clock.
  - In T[NT-1] it advances only when MEM_READY=1. While MEM_READY=0 it holds (wait state) and all outputs stay stable.
  - The wrap T[NT-1] to T[0] toggles the phase.
- Fetch strobes: IR_LOAD = PC_INC = FETCH & T[NT-1] & MEM_READY. Exactly one pulse per fetch, regardless of the number of wait states.
- Decode: I_STA = EXECUTE & (OPCODE==OP_STA). This is combinational; OPCODE must be stable through EXECUTE.
- Write chain:
  - SETWRITE = I_STA & T[0].
  - WRITE is set on the following edge and stays 1 until cleared.
  - DO_WRITE = WRITE & T[NT-1]; it stays asserted through wait states.
  - CLRWRITE = WRITE & T[NT-1] & MEM_READY; WRITE=0 on the following edge.
  - If SETWRITE and CLRWRITE are both asserted, set wins. This cannot occur for NT>=3 and is asserted against in simulation.
- Instruction retire: on the EXECUTE wrap (T[NT-1] & MEM_READY), INSTR_CNT increments by 1, wrapping modulo 2^CW.
- Halt:
  - HALT_REQ is sampled only at the EXECUTE wrap. If it is 1, the next state is HALT instead of RUN_FETCH.
  - HALT_REQ asserted during FETCH or mid-EXECUTE lets the current instruction complete.
  - In HALT, HALT_REQ=0 moves to RUN_FETCH with T[0] on the next edge.
  - A halted instruction is still counted.
- MEM_READY is ignored in T-states other than T[NT-1] and in HALT.

Optional Feature:
- DUNC_SINGLE_STEP_EN defined:
  - Adds input STEP (1 bit), which has an internal rising-edge detector.
  - In HALT, a STEP rising edge leaves HALT and executes exactly one instruction (fetch + execute), then returns to HALT even if HALT_REQ=0 by then.
  - STEP is ignored outside HALT.
- Not defined: the STEP port and its logic are absent, and the behaviour is exactly as above.

Decomposition:
- Package dunc_pkg holds:
  - opcode constants (OP_STA and the other dunc opcodes);
  - the state encoding enum (RUN_FETCH, RUN_EXEC, HALT);
  - default NT/CW localparams.
- One sub-module, dunc_tring: parametrised NT-bit one-hot ring counter.
  - Inputs: hold enable and clear-to-zero.
  - Output: T vector.
  - Async active-low reset to T[0].

Test Plan:
- Reset then free run, NT=4, MEM_READY=1, OPCODE=4'h1:
  - T cycles 1,2,4,8; FETCH and EXECUTE alternate every 4 clocks.
  - INSTR_CNT=5 after 40 clocks.
  - WRITE never asserts.
- STA, NT=4, MEM_READY=1, OPCODE=OP_STA:
  - SETWRITE in EXECUTE T[0].
  - WRITE=1 at T[1]..T[3].
  - DO_WRITE and CLRWRITE in T[3]; WRITE=0 at the next fetch T[0].
- Wait states, NT=5, MEM_READY held 0 for 3 clocks in fetch T[4]:
  - T stays 16 for 3 extra clocks.
  - IR_LOAD and PC_INC pulse exactly once, on the clock MEM_READY=1.
- Halt:
  - HALT_REQ=1 raised at fetch T[1]: the instruction completes, then HALTED=1 and T=0.
  - INSTR_CNT increments once, then freezes.
  - Drop HALT_REQ: FETCH T[0] on the next edge.
- Reset mid-write: RESET=0 during STA EXECUTE T[2] drops WRITE and DO_WRITE to 0 before the next CLK edge; after release, FETCH T[0] and INSTR_CNT=0.
- DUNC_SINGLE_STEP_EN defined, held in HALT with HALT_REQ=0 applied after entry: a single STEP pulse gives 2*NT clocks of run, then HALTED=1, and INSTR_CNT increments by exactly 1.
